// File: rtl/multicycle_control.sv
// Multicycle MIPS-subset control unit: Moore FSM decoding datapath controls
// from the current state, with a MemReady wait timeout that raises MemFault.
module multicycle_control #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Opcode,
   input  logic [5:0] Funct,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSource,
   output logic [3:0] ALUControl,
   output logic [3:0] State,
   output logic       IllegalOp,
   output logic       MemFault
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_REX    = 4'd6,
      S_RWB    = 4'd7,
      S_BEQ    = 4'd8,
      S_JMP    = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // Last wait count before the fault fires: the MEM_TIMEOUT-th idle cycle.
   localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic [7:0] wait_q, wait_d;
   logic       ill_q, ill_d;
   logic       flt_q, flt_d;

   logic       waiting;
   logic       timeout;
   logic       pc_write;
   logic       ir_wr, reg_wr, mem_wr;

   assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   // MemReady in the final cycle wins over the timeout.
   assign timeout = waiting && !MemReady && (wait_q == WAIT_LAST);

   // State, wait counter and fault pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         ill_q   <= 1'b0;
         flt_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         ill_q   <= ill_d;
         flt_q   <= flt_d;
      end
   end

   // Next-state, wait counter and fault decisions.
   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      ill_d   = 1'b0;
      flt_d   = 1'b0;
      case (state_q)
         S_FETCH:  if (MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (Opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_REX;
               OP_BEQ:       state_d = S_BEQ;
               OP_J:         state_d = S_JMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  state_d = S_FETCH;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_MEMADR: state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (MemReady) state_d = S_MEMWB;
         S_MEMWR:  if (MemReady) state_d = S_FETCH;
         S_REX: begin
            case (Funct)
               6'b100000, 6'b100010, 6'b100100,
               6'b100101, 6'b101010, 6'b100111: state_d = S_RWB;
               default: begin
                  state_d = S_FETCH;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_ADDIEX: state_d = S_ADDIWB;
         default:  state_d = S_FETCH;
      endcase

      if (timeout) begin
         state_d = S_FETCH;
         flt_d   = 1'b1;
      end

      // Any state change (or a fault re-entering FETCH) restarts the count.
      if ((state_d != state_q) || timeout) begin
         wait_d = '0;
      end else if (waiting && !MemReady) begin
         wait_d = wait_q + 8'd1;
      end
   end

   // Moore output decode from the current state.
   always_comb begin
      pc_write   = 1'b0;
      ir_wr      = 1'b0;
      reg_wr     = 1'b0;
      mem_wr     = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      PCSource   = 2'b00;
      ALUControl = 4'b0010;
      case (state_q)
         S_FETCH: begin
            MemRead  = MemReady;
            ir_wr    = MemReady;
            pc_write = MemReady;
            ALUSrcB  = 2'b01;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMWB: begin
            reg_wr   = 1'b1;
            MemtoReg = 1'b1;
         end
         S_MEMWR: begin
            IorD   = 1'b1;
            mem_wr = 1'b1;
         end
         S_REX: begin
            ALUSrcA = 1'b1;
            case (Funct)
               6'b100010: ALUControl = 4'b0110;
               6'b100100: ALUControl = 4'b0000;
               6'b100101: ALUControl = 4'b0001;
               6'b101010: ALUControl = 4'b0111;
               6'b100111: ALUControl = 4'b1100;
               default:   ALUControl = 4'b0010;
            endcase
         end
         S_RWB: begin
            reg_wr = 1'b1;
            RegDst = 1'b1;
         end
         S_BEQ: begin
            ALUSrcA    = 1'b1;
            ALUControl = 4'b0110;
            PCSource   = 2'b01;
         end
         S_JMP: begin
            PCSource = 2'b10;
            pc_write = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_ADDIWB: reg_wr = 1'b1;
         default: ;
      endcase
   end

   // Write enables are held off for as long as reset is asserted.
   assign PCEn      = (pc_write | ((state_q == S_BEQ) & Zero)) & ~reset;
   assign IRWrite   = ir_wr  & ~reset;
   assign RegWrite  = reg_wr & ~reset;
   assign MemWrite  = mem_wr & ~reset;
   assign State     = state_q;
   assign IllegalOp = ill_q;
   assign MemFault  = flt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expectations are queued per step and
// popped/compared at the falling edge of each cycle.
module tb_multicycle_control;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] Opcode, Funct;
   logic       Zero, MemReady;
   logic       PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSource;
   logic [3:0] ALUControl, State;
   logic       IllegalOp, MemFault;

   int compared   = 0;
   int mismatched = 0;

   localparam int F_ST = 0, F_PCEN = 1, F_RW = 2, F_M2R = 3, F_ALUC = 4, F_ILL = 5,
                  F_FLT = 6, F_PCS = 7, F_MW = 8, F_IRW = 9, F_MR = 10, F_IORD = 11,
                  F_RDST = 12, F_SRCB = 13, F_SRCA = 14;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] val;
   } exp_t;
   exp_t sb[$];

   multicycle_control #(.MEM_TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
      .MemReady(MemReady), .PCEn(PCEn), .IorD(IorD), .MemRead(MemRead),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .ALUControl(ALUControl), .State(State), .IllegalOp(IllegalOp), .MemFault(MemFault)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] getf(input int sel);
      case (sel)
         F_ST:    return {4'b0, State};
         F_PCEN:  return {7'b0, PCEn};
         F_RW:    return {7'b0, RegWrite};
         F_M2R:   return {7'b0, MemtoReg};
         F_ALUC:  return {4'b0, ALUControl};
         F_ILL:   return {7'b0, IllegalOp};
         F_FLT:   return {7'b0, MemFault};
         F_PCS:   return {6'b0, PCSource};
         F_MW:    return {7'b0, MemWrite};
         F_IRW:   return {7'b0, IRWrite};
         F_MR:    return {7'b0, MemRead};
         F_IORD:  return {7'b0, IorD};
         F_RDST:  return {7'b0, RegDst};
         F_SRCB:  return {6'b0, ALUSrcB};
         default: return {7'b0, ALUSrcA};
      endcase
   endfunction

   task automatic ex(input string tag, input int sel, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = v;
      sb.push_back(e);
   endtask

   // Compare all queued expectations mid-cycle, then advance past the next edge.
   task automatic cyc();
      exp_t       e;
      logic [7:0] obs;
      @(negedge clk);
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = getf(e.sel);
         compared++;
         assert (obs === e.val) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h at %0t", e.tag, obs, e.val, $time);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_ok(input string tag);
      MemReady = 1'b1;
      ex({tag, " fetch state"}, F_ST, 8'd0);
      ex({tag, " fetch IRWrite"}, F_IRW, 8'd1);
      ex({tag, " fetch PCEn"}, F_PCEN, 8'd1);
      ex({tag, " fetch MemRead"}, F_MR, 8'd1);
      ex({tag, " fetch RegWrite"}, F_RW, 8'd0);
      cyc();
   endtask

   task automatic decode(input string tag);
      ex({tag, " decode state"}, F_ST, 8'd1);
      ex({tag, " decode ALUSrcB"}, F_SRCB, 8'd3);
      ex({tag, " decode PCEn"}, F_PCEN, 8'd0);
      cyc();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed no finish, required finish before 100us");
      $fatal;
   end

   initial begin
      reset = 1'b1; MemReady = 1'b1; Opcode = 6'b100011; Funct = 6'b0; Zero = 1'b0;
      // Reset held with MemReady high: no write enables, no fault pulses.
      for (int unsigned i = 0; i < 2; i++) begin
         ex("rst state", F_ST, 8'd0);
         ex("rst PCEn", F_PCEN, 8'd0);
         ex("rst IRWrite", F_IRW, 8'd0);
         ex("rst RegWrite", F_RW, 8'd0);
         ex("rst MemWrite", F_MW, 8'd0);
         ex("rst IllegalOp", F_ILL, 8'd0);
         ex("rst MemFault", F_FLT, 8'd0);
         cyc();
      end
      reset = 1'b0;

      // lw: 0,1,2,3,4,0
      fetch_ok("lw");
      decode("lw");
      ex("lw memadr state", F_ST, 8'd2); ex("lw memadr srcA", F_SRCA, 8'd1);
      ex("lw memadr srcB", F_SRCB, 8'd2); ex("lw memadr RegWrite", F_RW, 8'd0);
      cyc();
      ex("lw memrd state", F_ST, 8'd3); ex("lw memrd IorD", F_IORD, 8'd1);
      ex("lw memrd MemRead", F_MR, 8'd1); ex("lw memrd RegWrite", F_RW, 8'd0);
      cyc();
      ex("lw memwb state", F_ST, 8'd4); ex("lw memwb RegWrite", F_RW, 8'd1);
      ex("lw memwb MemtoReg", F_M2R, 8'd1); ex("lw memwb RegDst", F_RDST, 8'd0);
      cyc();

      // R-type sub
      Opcode = 6'b000000; Funct = 6'b100010;
      fetch_ok("sub");
      decode("sub");
      ex("sub rex state", F_ST, 8'd6); ex("sub rex aluc", F_ALUC, 8'h6);
      ex("sub rex srcA", F_SRCA, 8'd1); ex("sub rex srcB", F_SRCB, 8'd0);
      cyc();
      ex("sub rwb state", F_ST, 8'd7); ex("sub rwb RegWrite", F_RW, 8'd1);
      ex("sub rwb RegDst", F_RDST, 8'd1);
      cyc();

      // R-type nor
      Funct = 6'b100111;
      fetch_ok("nor");
      decode("nor");
      ex("nor rex state", F_ST, 8'd6); ex("nor rex aluc", F_ALUC, 8'hc);
      cyc();
      ex("nor rwb state", F_ST, 8'd7);
      cyc();

      // Illegal Funct: back to FETCH with IllegalOp, RegWrite never set
      Funct = 6'b000000;
      fetch_ok("badfn");
      decode("badfn");
      ex("badfn rex state", F_ST, 8'd6); ex("badfn rex RegWrite", F_RW, 8'd0);
      ex("badfn rex aluc", F_ALUC, 8'h2);
      cyc();
      Opcode = 6'b111111;
      ex("badfn ill pulse", F_ILL, 8'd1); ex("badfn ill RegWrite", F_RW, 8'd0);
      fetch_ok("badfn");

      // Illegal opcode in DECODE; then FETCH held with MemReady low
      decode("badop");
      MemReady = 1'b0;
      ex("badop ill pulse", F_ILL, 8'd1); ex("badop state", F_ST, 8'd0);
      ex("badop hold IRWrite", F_IRW, 8'd0); ex("badop hold PCEn", F_PCEN, 8'd0);
      cyc();

      // beq taken (Zero ignored during DECODE)
      Opcode = 6'b000100; Zero = 1'b1;
      ex("beq1 ill cleared", F_ILL, 8'd0);
      fetch_ok("beq1");
      decode("beq1");
      ex("beq1 state", F_ST, 8'd8); ex("beq1 PCEn", F_PCEN, 8'd1);
      ex("beq1 PCSource", F_PCS, 8'd1); ex("beq1 aluc", F_ALUC, 8'h6);
      cyc();
      Zero = 1'b0;
      fetch_ok("beq0");
      decode("beq0");
      ex("beq0 state", F_ST, 8'd8); ex("beq0 PCEn", F_PCEN, 8'd0);
      ex("beq0 PCSource", F_PCS, 8'd1);
      cyc();

      // jump
      Opcode = 6'b000010;
      fetch_ok("j");
      decode("j");
      ex("j state", F_ST, 8'd9); ex("j PCEn", F_PCEN, 8'd1); ex("j PCSource", F_PCS, 8'd2);
      cyc();

      // addi
      Opcode = 6'b001000;
      fetch_ok("addi");
      decode("addi");
      ex("addi ex state", F_ST, 8'd10); ex("addi ex srcB", F_SRCB, 8'd2);
      ex("addi ex srcA", F_SRCA, 8'd1); ex("addi ex aluc", F_ALUC, 8'h2);
      cyc();
      ex("addi wb state", F_ST, 8'd11); ex("addi wb RegWrite", F_RW, 8'd1);
      ex("addi wb RegDst", F_RDST, 8'd0); ex("addi wb MemtoReg", F_M2R, 8'd0);
      cyc();

      // sw with MemReady low 15 cycles: fault
      Opcode = 6'b101011;
      fetch_ok("swto");
      decode("swto");
      ex("swto memadr state", F_ST, 8'd2);
      cyc();
      MemReady = 1'b0;
      for (int unsigned i = 0; i < 15; i++) begin
         ex("swto wait state", F_ST, 8'd5); ex("swto wait MemWrite", F_MW, 8'd1);
         ex("swto wait fault", F_FLT, 8'd0);
         cyc();
      end
      ex("swto fault state", F_ST, 8'd0); ex("swto fault pulse", F_FLT, 8'd1);
      ex("swto fault MemWrite", F_MW, 8'd0); ex("swto fault PCEn", F_PCEN, 8'd0);
      ex("swto fault RegWrite", F_RW, 8'd0);
      cyc();

      // sw with MemReady rising on the 15th cycle: no fault
      ex("swok fault cleared", F_FLT, 8'd0);
      fetch_ok("swok");
      decode("swok");
      ex("swok memadr state", F_ST, 8'd2);
      cyc();
      MemReady = 1'b0;
      for (int unsigned i = 0; i < 14; i++) begin
         ex("swok wait state", F_ST, 8'd5);
         cyc();
      end
      MemReady = 1'b1;
      ex("swok last state", F_ST, 8'd5); ex("swok last MemWrite", F_MW, 8'd1);
      ex("swok last fault", F_FLT, 8'd0);
      cyc();
      Opcode = 6'b100011;
      ex("swok after fault", F_FLT, 8'd0);
      fetch_ok("swok next");

      // lw stalled in MEMRD, then asynchronous reset
      decode("lwrst");
      ex("lwrst memadr state", F_ST, 8'd2);
      cyc();
      MemReady = 1'b0;
      for (int unsigned i = 0; i < 3; i++) begin
         ex("lwrst wait state", F_ST, 8'd3);
         cyc();
      end
      reset = 1'b1;
      ex("lwrst async state", F_ST, 8'd0); ex("lwrst async RegWrite", F_RW, 8'd0);
      ex("lwrst async fault", F_FLT, 8'd0); ex("lwrst async ill", F_ILL, 8'd0);
      cyc();
      MemReady = 1'b1;
      ex("lwrst held IRWrite", F_IRW, 8'd0); ex("lwrst held PCEn", F_PCEN, 8'd0);
      ex("lwrst held RegWrite", F_RW, 8'd0);
      cyc();
      reset = 1'b0;
      fetch_ok("lwrst after");
      decode("lwrst after");
      ex("lwrst after memadr", F_ST, 8'd2);
      cyc();
      ex("lwrst after memrd", F_ST, 8'd3);
      cyc();
      ex("lwrst after memwb", F_ST, 8'd4); ex("lwrst after RegWrite", F_RW, 8'd1);
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
